// File: rtl/async_sched_pkg.sv
// Shared types, widths and the hold-off reload helper for the ASYNC trigger scheduler.
package async_sched_pkg;

  localparam int ADDR_W          = 16;
  localparam int CNT_W           = 16;
  localparam int WIN_W           = 24;
  localparam int HOLD_W          = 13;
  localparam int BURST_W         = 11;
  localparam int ADDRS_PER_BURST = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    CLOSE = 2'd3
  } sched_state_t;

  // Reload is H-1 = 4*(n+1)-1 = 4*n+3; the largest value (8191) still fits HOLD_W bits.
  function automatic logic [HOLD_W-1:0] holdoff_reload(input logic [BURST_W-1:0] num_bursts);
    logic [HOLD_W-1:0] h;
    h = HOLD_W'(num_bursts) * HOLD_W'(ADDRS_PER_BURST) + HOLD_W'(ADDRS_PER_BURST - 1);
    return h;
  endfunction

endpackage

// File: rtl/async_trig_scheduler_if.sv
// Mover-side bundle: circular-buffer enables, trigger-address FIFO and mover status.
interface async_trig_scheduler_if;
  import async_sched_pkg::*;

  logic              cbuf_trig_en;
  logic              cbuf_rd_en;
  logic              cbuf_rd_trig_wait;
  logic              trig_fifo_wr_en;
  logic              trig_fifo_full;
  logic              trig_fifo_empty;
  logic [ADDR_W-1:0] trig_fifo_din;
  logic [ADDR_W-1:0] circ_buf_wr_addr;

  modport master (
    output cbuf_trig_en, cbuf_rd_en, trig_fifo_wr_en, trig_fifo_din,
    input  cbuf_rd_trig_wait, trig_fifo_full, trig_fifo_empty, circ_buf_wr_addr
  );

  modport slave (
    input  cbuf_trig_en, cbuf_rd_en, trig_fifo_wr_en, trig_fifo_din,
    output cbuf_rd_trig_wait, trig_fifo_full, trig_fifo_empty, circ_buf_wr_addr
  );

endinterface

// File: rtl/async_holdoff_cntr.sv
// Rising-edge detector on the synchronized trigger plus the per-waveform hold-off down-counter.
module async_holdoff_cntr
  import async_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_in,
  input  logic              clear,
  input  logic              load,
  input  logic [HOLD_W-1:0] reload,
  output logic              trig_edge,
  output logic              holdoff_clear
);

  logic              trig_q;
  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      cnt    <= '0;
    end else begin
      trig_q <= trig_in;
      if (clear)
        cnt <= '0;
      else if (load)
        cnt <= reload;
      else if (cnt != '0)
        cnt <= cnt - HOLD_W'(1);
    end
  end

  assign trig_edge     = trig_in & ~trig_q;
  assign holdoff_clear = (cnt == '0);

endmodule

// File: rtl/async_trig_scheduler.sv
// Sequences one ASYNC fill: opens trigger/read enables, qualifies trigger edges and
// queues accepted trigger addresses for the circular-buffer-to-DDR3 mover.
//   state | meaning
//   IDLE  | no fill, all enables low
//   ARMED | triggers accepted, mover enabled
//   DRAIN | triggers closed, mover finishing queued waveforms
//   CLOSE | mover disabled for one cycle, fill_done pulse
module async_trig_scheduler
  import async_sched_pkg::*;
(
  input  logic                  adc_clk,
  input  logic                  reset_clk_adc,
  input  logic                  fill_start,
  input  logic                  fill_stop,
  input  logic [WIN_W-1:0]      fill_window_clks,
  input  logic [CNT_W-1:0]      max_triggers,
  input  logic [BURST_W-1:0]    async_num_bursts,
  input  logic                  trig_in,
  async_trig_scheduler_if.master mover,
  output logic                  fill_active,
  output logic                  fill_done,
  output logic [CNT_W-1:0]      trig_count,
  output logic [CNT_W-1:0]      trig_drop_count
);

  sched_state_t      state, state_nxt;
  logic [WIN_W-1:0]  win_cnt;
  logic [HOLD_W-1:0] holdoff_ld;
  logic              trig_edge, holdoff_clear;
  logic              start_fill, limit_ok, accept, drop, win_exit, limit_exit;

  assign holdoff_ld = holdoff_reload(async_num_bursts);

  async_holdoff_cntr u_holdoff (
    .clk           (adc_clk),
    .rst           (reset_clk_adc),
    .trig_in       (trig_in),
    .clear         (start_fill),
    .load          (accept),
    .reload        (holdoff_ld),
    .trig_edge     (trig_edge),
    .holdoff_clear (holdoff_clear)
  );

  always_comb begin
    state_nxt  = state;
    start_fill = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    limit_exit = 1'b0;
    limit_ok   = (max_triggers == '0) || (trig_count < max_triggers);
    // A zero window never reaches 1, so an unlimited window needs no extra flag.
    win_exit   = (win_cnt == WIN_W'(1));
    case (state)
      IDLE: begin
        if (fill_start) begin
          start_fill = 1'b1;
          state_nxt  = ARMED;
        end
      end
      ARMED: begin
        if (fill_stop) begin
          state_nxt = DRAIN;
        end else begin
          if (trig_edge) begin
            if (holdoff_clear && !mover.trig_fifo_full && limit_ok)
              accept = 1'b1;
            else
              drop = 1'b1;
          end
          limit_exit = (max_triggers != '0) &&
                       ((accept && (trig_count + CNT_W'(1) == max_triggers)) ||
                        (trig_count >= max_triggers));
          if (win_exit || limit_exit)
            state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mover.trig_fifo_empty && mover.cbuf_rd_trig_wait)
          state_nxt = CLOSE;
      end
      CLOSE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (reset_clk_adc) begin
      state                 <= IDLE;
      win_cnt               <= '0;
      trig_count            <= '0;
      trig_drop_count       <= '0;
      fill_active           <= 1'b0;
      fill_done             <= 1'b0;
      mover.cbuf_trig_en    <= 1'b0;
      mover.cbuf_rd_en      <= 1'b0;
      mover.trig_fifo_wr_en <= 1'b0;
      mover.trig_fifo_din   <= '0;
    end else begin
      state                 <= state_nxt;
      fill_active           <= (state_nxt != IDLE);
      fill_done             <= (state_nxt == CLOSE);
      mover.cbuf_trig_en    <= (state_nxt == ARMED);
      mover.cbuf_rd_en      <= (state_nxt == ARMED) || (state_nxt == DRAIN);
      mover.trig_fifo_wr_en <= accept;
      if (accept)
        mover.trig_fifo_din <= mover.circ_buf_wr_addr;
      if (start_fill) begin
        win_cnt         <= fill_window_clks;
        trig_count      <= '0;
        trig_drop_count <= '0;
      end else begin
        if (state == ARMED && win_cnt != '0)
          win_cnt <= win_cnt - WIN_W'(1);
        if (accept)
          trig_count <= trig_count + CNT_W'(1);
        if (drop && trig_drop_count != '1)
          trig_drop_count <= trig_drop_count + CNT_W'(1);
      end
    end
  end

endmodule
